// File: rtl/dmem_responder.sv
// Word-addressed data-memory slave with a req/ready request side and a one-cycle response pulse.
// Accesses that are misaligned or out of range return an error instead of aliasing.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ReqReady high, waiting for Req
// ST_WAIT | request latched, counting down wait states
// ST_RESP | RespValid pulse, ReadData/RespErr valid
module dmem_responder #(
   parameter int ADDR_WORDS = 64,
   parameter int WAIT       = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Req,
   input  logic        Write,
   input  logic [31:0] Adr,
   input  logic [31:0] WriteData,
   output logic        ReqReady,
   output logic        RespValid,
   output logic [31:0] ReadData,
   output logic        RespErr
);

   localparam int         IW        = (ADDR_WORDS > 1) ? $clog2(ADDR_WORDS) : 1;
   localparam bit         ZERO_WAIT = (WAIT == 0);
   localparam logic [3:0] WAIT_LOAD = ZERO_WAIT ? 4'd0 : 4'(WAIT - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic        req_write;
   logic [31:0] req_adr;
   logic [31:0] req_wdata;

   logic [31:0] mem [ADDR_WORDS];

   logic        c_write;
   logic [31:0] c_adr;
   logic [31:0] c_wdata;
   logic [29:0] c_idx;
   logic        c_err;
   logic        commit;
   logic [31:0] rd_word;

   // With zero wait states the commit edge is the acceptance edge, so the live bus is used.
   always_comb begin
      c_write = req_write;
      c_adr   = req_adr;
      c_wdata = req_wdata;
      if (state == ST_IDLE) begin
         c_write = Write;
         c_adr   = Adr;
         c_wdata = WriteData;
      end
      c_idx   = c_adr[31:2];
      c_err   = (c_adr[1:0] != 2'b00) || ({2'b00, c_idx} >= 32'(ADDR_WORDS));
      commit  = ((state == ST_IDLE) && Req && ZERO_WAIT) ||
                ((state == ST_WAIT) && (cnt == 4'd0));
      rd_word = mem[c_idx[IW-1:0]];
   end

   always_ff @(posedge clk) begin
      if (!reset && commit && c_write && !c_err) begin
         mem[c_idx[IW-1:0]] <= c_wdata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         cnt       <= 4'd0;
         ReqReady  <= 1'b1;
         RespValid <= 1'b0;
         ReadData  <= 32'd0;
         RespErr   <= 1'b0;
         req_write <= 1'b0;
         req_adr   <= 32'd0;
         req_wdata <= 32'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (Req) begin
                  req_write <= Write;
                  req_adr   <= Adr;
                  req_wdata <= WriteData;
                  ReqReady  <= 1'b0;
                  if (ZERO_WAIT) begin
                     state     <= ST_RESP;
                     RespValid <= 1'b1;
                  end else begin
                     state <= ST_WAIT;
                     cnt   <= WAIT_LOAD;
                  end
               end
            end
            ST_WAIT: begin
               if (cnt == 4'd0) begin
                  state     <= ST_RESP;
                  RespValid <= 1'b1;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            ST_RESP: begin
               state     <= ST_IDLE;
               RespValid <= 1'b0;
               ReqReady  <= 1'b1;
            end
            default: begin
               state     <= ST_IDLE;
               RespValid <= 1'b0;
               ReqReady  <= 1'b1;
            end
         endcase
         if (commit) begin
            ReadData <= (!c_write && !c_err) ? rd_word : 32'd0;
            RespErr  <= c_err;
         end
      end
   end

endmodule
